// File: rtl/puf_ctrl_pkg.sv
// Shared types and helpers for the ring-oscillator PUF challenge sequencer.
package puf_ctrl_pkg;

  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_WINDOW_CYC = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_COMPARE = 3'd5,
    ST_DONE    = 3'd6
  } puf_state_e;

  // Bit offset of oscillator pair idx inside a packed challenge word
  function automatic int unsigned pair_lsb(input int unsigned idx, input int unsigned pair_w);
    return idx * pair_w;
  endfunction

endpackage

// File: rtl/puf_cycle_timer.sv
// Loadable down-counter; o_expire_c is high on the last cycle of a loaded interval.
// Loading value V gives an interval of V+1 cycles.
module puf_cycle_timer #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire_c
);

  logic [CNT_W-1:0] r_count;
  logic             r_active;

  // Count down after a load; go inactive once zero has been reached
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_expire_c = r_active && (r_count == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF challenge sequencer: for each oscillator pair of a challenge,
// select rings, clear counters, settle, measure for a fixed window, drain and compare.
// Optional build macro PUF_MAJORITY_EN: each non-degenerate pair is measured three
// times and the response bit is the majority vote; any tied run flags the tie mask.
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned WINDOW_CYC = DEF_WINDOW_CYC
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start_valid,
  output logic                      o_start_ready,
  input  logic [N_BITS*2*SEL_W-1:0] i_challenge,
  output logic                      o_osc_en,
  output logic [SEL_W-1:0]          o_sel_a,
  output logic [SEL_W-1:0]          o_sel_b,
  output logic                      o_cnt_clr,
  input  logic [CNT_W-1:0]          i_cnt_a,
  input  logic [CNT_W-1:0]          i_cnt_b,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [N_BITS-1:0]         o_response,
  output logic [N_BITS-1:0]         o_tie_mask,
  output logic                      o_busy
);

  localparam int unsigned PAIR_W  = 2 * SEL_W;
  localparam int unsigned CH_W    = N_BITS * PAIR_W;
  localparam int unsigned IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYC - 1);

  puf_state_e        r_state;
  logic [CH_W-1:0]   r_chal;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [SEL_W-1:0]  r_sel_a;
  logic [SEL_W-1:0]  r_sel_b;
  logic              r_osc_en;
  logic              r_cnt_clr;
  logic              r_resp_valid;
  logic              r_busy;
  logic              r_start_ready;
  logic [N_BITS-1:0] r_resp;
  logic [N_BITS-1:0] r_tie;

  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_expire;
  logic              w_degen;
  logic              w_last;
  logic              w_gt;
  logic              w_eq;
  logic              w_bit;
  logic              w_tie;
  logic [PAIR_W-1:0] w_first_pair;
  logic [PAIR_W-1:0] w_next_pair;

  assign w_first_pair = i_challenge[PAIR_W-1:0];
  assign w_next_pair  = PAIR_W'(r_chal >> pair_lsb(32'(r_bit_idx) + 32'd1, PAIR_W));
  assign w_degen      = (r_sel_a == r_sel_b);
  assign w_last       = (r_bit_idx == IDX_W'(N_BITS - 1));
  assign w_gt         = (i_cnt_a > i_cnt_b);
  assign w_eq         = (i_cnt_a == i_cnt_b);

`ifdef PUF_MAJORITY_EN
  logic [1:0] r_run;
  logic [1:0] r_votes;
  logic       r_any_tie;
  logic       w_more_runs;

  assign w_more_runs = (r_run != 2'd2);
  assign w_bit       = ((r_votes + 2'(w_gt)) >= 2'd2);
  assign w_tie       = r_any_tie | w_eq;
`else
  assign w_bit = w_gt;
  assign w_tie = w_eq;
`endif

  // Timer reload on entry to each timed phase
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      ST_SETUP: begin
        if (!w_degen) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_expire) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = WINDOW_LD;
        end
      end
      ST_MEASURE: begin
        if (w_tmr_expire) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = SETTLE_LD;
        end
      end
`ifdef PUF_MAJORITY_EN
      ST_COMPARE: begin
        if (w_more_runs) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = SETTLE_LD;
        end
      end
`endif
      default: ;
    endcase
  end

  puf_cycle_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire_c (w_tmr_expire)
  );

  // Sequencer FSM; every output is set for the state being entered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_chal        <= '0;
      r_bit_idx     <= '0;
      r_sel_a       <= '0;
      r_sel_b       <= '0;
      r_osc_en      <= 1'b0;
      r_cnt_clr     <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
      r_resp        <= '0;
      r_tie         <= '0;
`ifdef PUF_MAJORITY_EN
      r_run         <= '0;
      r_votes       <= '0;
      r_any_tie     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start_valid) begin
            r_chal        <= i_challenge;
            r_bit_idx     <= '0;
            r_resp        <= '0;
            r_tie         <= '0;
            r_sel_a       <= w_first_pair[SEL_W-1:0];
            r_sel_b       <= w_first_pair[PAIR_W-1:SEL_W];
            r_cnt_clr     <= 1'b1;
            r_osc_en      <= 1'b0;
            r_busy        <= 1'b1;
            r_start_ready <= 1'b0;
            r_state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_degen) begin
            r_resp[r_bit_idx] <= 1'b0;
            r_tie[r_bit_idx]  <= 1'b1;
            if (w_last) begin
              r_cnt_clr    <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_sel_a   <= w_next_pair[SEL_W-1:0];
              r_sel_b   <= w_next_pair[PAIR_W-1:SEL_W];
              r_state   <= ST_SETUP;
            end
          end else begin
            r_osc_en  <= 1'b1;
            r_cnt_clr <= 1'b1;
            r_state   <= ST_SETTLE;
`ifdef PUF_MAJORITY_EN
            r_run     <= '0;
            r_votes   <= '0;
            r_any_tie <= 1'b0;
`endif
          end
        end
        ST_SETTLE: begin
          if (w_tmr_expire) begin
            r_cnt_clr <= 1'b0;
            r_state   <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_tmr_expire) begin
            r_osc_en <= 1'b0;
            r_state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_tmr_expire) begin
            r_state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
`ifdef PUF_MAJORITY_EN
          if (w_more_runs) begin
            r_run     <= r_run + 2'd1;
            r_votes   <= r_votes + 2'(w_gt);
            r_any_tie <= r_any_tie | w_eq;
            r_osc_en  <= 1'b1;
            r_cnt_clr <= 1'b1;
            r_state   <= ST_SETTLE;
          end else begin
`else
          begin
`endif
            r_resp[r_bit_idx] <= w_bit;
            r_tie[r_bit_idx]  <= w_tie;
            if (w_last) begin
              r_resp_valid <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_sel_a   <= w_next_pair[SEL_W-1:0];
              r_sel_b   <= w_next_pair[PAIR_W-1:SEL_W];
              r_cnt_clr <= 1'b1;
              r_state   <= ST_SETUP;
            end
          end
        end
        ST_DONE: begin
          if (i_resp_ready) begin
            r_resp_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_start_ready = r_start_ready;
  assign o_osc_en      = r_osc_en;
  assign o_sel_a       = r_sel_a;
  assign o_sel_b       = r_sel_b;
  assign o_cnt_clr     = r_cnt_clr;
  assign o_resp_valid  = r_resp_valid;
  assign o_response    = r_resp;
  assign o_tie_mask    = r_tie;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer with a behavioural edge-counter model.
module tb_puf_challenge_sequencer;

  localparam int unsigned N_BITS     = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned WINDOW_CYC = 16;
  localparam int unsigned PAIR_W     = 2 * SEL_W;
  localparam int unsigned CH_W       = N_BITS * PAIR_W;
`ifdef PUF_MAJORITY_EN
  localparam int unsigned RUNS = 3;
`else
  localparam int unsigned RUNS = 1;
`endif
  localparam int BIT_LAT = int'(RUNS * (1 + 2 * SETTLE_CYC + WINDOW_CYC) + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic [CH_W-1:0]   challenge;
  logic              osc_en;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [N_BITS-1:0] response;
  logic [N_BITS-1:0] tie_mask;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int run_cnt = 0;
  int cur_run = 0;
  logic osc_q = 1'b0;
  logic [CNT_W-1:0] tgt_a [32];
  logic [CNT_W-1:0] tgt_b [32];

  typedef struct {
    logic [N_BITS-1:0] resp;
    logic [N_BITS-1:0] tie;
    int                lat;
  } exp_t;
  exp_t sb[$];

  puf_challenge_sequencer #(
    .N_BITS     (N_BITS),
    .SEL_W      (SEL_W),
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE_CYC),
    .WINDOW_CYC (WINDOW_CYC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start_valid (start_valid),
    .o_start_ready (start_ready),
    .i_challenge   (challenge),
    .o_osc_en      (osc_en),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_cnt_clr     (cnt_clr),
    .i_cnt_a       (cnt_a),
    .i_cnt_b       (cnt_b),
    .o_resp_valid  (resp_valid),
    .i_resp_ready  (resp_ready),
    .o_response    (response),
    .o_tie_mask    (tie_mask),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge counters: cleared by cnt_clr, accumulate to the scripted count of the current run while enabled
  always @(posedge clk) begin
    if (osc_en === 1'b1 && osc_q === 1'b0) begin
      cur_run = run_cnt;
      run_cnt = run_cnt + 1;
    end
    osc_q <= osc_en;
    if (cnt_clr === 1'b1) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (osc_en === 1'b1) begin
      cnt_a <= tgt_a[cur_run & 31];
      cnt_b <= tgt_b[cur_run & 31];
    end
  end

  function automatic exp_t model(input logic [CH_W-1:0] ch);
    exp_t e;
    int run, votes;
    bit anytie;
    logic [PAIR_W-1:0] p;
    e.resp = '0; e.tie = '0; e.lat = 0; run = 0;
    for (int i = 0; i < int'(N_BITS); i++) begin
      p = PAIR_W'(ch >> (i * int'(PAIR_W)));
      if (p[SEL_W-1:0] == p[PAIR_W-1:SEL_W]) begin
        e.tie[i] = 1'b1;
        e.lat += 1;
      end else begin
        votes = 0; anytie = 0;
        for (int r = 0; r < int'(RUNS); r++) begin
          if (tgt_a[run & 31] > tgt_b[run & 31]) votes++;
          if (tgt_a[run & 31] == tgt_b[run & 31]) anytie = 1;
          run++;
        end
        e.resp[i] = (2 * votes > int'(RUNS));
        e.tie[i]  = anytie;
        e.lat += BIT_LAT;
      end
    end
    return e;
  endfunction

  // k-th measured (non-degenerate) pair gets counts a/b for all of its runs
  task automatic set_meas(input int k, input int a, input int b);
    for (int r = 0; r < int'(RUNS); r++) begin
      tgt_a[(k * int'(RUNS) + r) & 31] = CNT_W'(a);
      tgt_b[(k * int'(RUNS) + r) & 31] = CNT_W'(b);
    end
  endtask

  task automatic send(input logic [CH_W-1:0] ch);
    @(negedge clk);
    run_cnt = 0;
    sb.push_back(model(ch));
    challenge   = ch;
    start_valid = 1'b1;
    for (int i = 0; i < 50 && start_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    acc_cyc     = cyc;
    start_valid = 1'b0;
    challenge   = ~ch;
  endtask

  task automatic wait_resp(output bit ok, output int lat);
    ok = 0; lat = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        ok = 1; lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; resp_ready = 1'b0; challenge = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({osc_en, cnt_clr, resp_valid, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got osc/clr/valid/busy=%b want 0000", {osc_en, cnt_clr, resp_valid, busy});
    end
    n_tests++;
    if ({sel_a, sel_b, response, tie_mask} !== '0) begin
      n_fail++; $display("FAIL reset_data got sel=%h/%h resp=%h tie=%h want zeros", sel_a, sel_b, response, tie_mask);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle got ready=%b busy=%b want 1 0", start_ready, busy);
    end
  endtask

  task automatic test_all_greater();
    exp_t e; bit ok; int lat;
    for (int k = 0; k < 4; k++) set_meas(k, 100, 90);
    send(16'h1B1B);
    n_tests++;
    if ({sel_a, sel_b, cnt_clr, osc_en, busy, start_ready} !== {2'd3, 2'd2, 4'b1010}) begin
      n_fail++; $display("FAIL setup_outputs got sel=%0d/%0d clr=%b osc=%b busy=%b rdy=%b want 3/2 1 0 1 0",
                         sel_a, sel_b, cnt_clr, osc_en, busy, start_ready);
    end
    wait_resp(ok, lat);
    e = sb.pop_front();
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL allgt_timeout no resp_valid"); end
    n_tests++;
    if (response !== 4'hF || tie_mask !== 4'h0) begin
      n_fail++; $display("FAIL allgt_resp got resp=%h tie=%h want F 0", response, tie_mask);
    end
    n_tests++;
    if (lat !== e.lat || lat !== 4 * BIT_LAT) begin
      n_fail++; $display("FAIL allgt_latency got %0d want %0d", lat, 4 * BIT_LAT);
    end
    n_tests++;
    if (osc_en !== 1'b0 || cnt_clr !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL done_ctrl got osc=%b clr=%b busy=%b want 0 0 1", osc_en, cnt_clr, busy);
    end
    ack();
  endtask

  task automatic test_degenerate();
    exp_t e; bit ok; int lat;
    set_meas(0, 100, 90); set_meas(1, 80, 90); set_meas(2, 100, 90);
    send(16'h1B5B);
    wait_resp(ok, lat);
    e = sb.pop_front();
    n_tests++;
    if (!ok || response !== e.resp || tie_mask !== e.tie) begin
      n_fail++; $display("FAIL degen_resp got ok=%b resp=%h tie=%h want resp=%h tie=%h", ok, response, tie_mask, e.resp, e.tie);
    end
    n_tests++;
    if (lat !== 3 * BIT_LAT + 1) begin
      n_fail++; $display("FAIL degen_latency got %0d want %0d", lat, 3 * BIT_LAT + 1);
    end
    ack();
    send(16'h5AF0);
    wait_resp(ok, lat);
    e = sb.pop_front();
    n_tests++;
    if (!ok || response !== 4'h0 || tie_mask !== 4'hF || lat !== 4) begin
      n_fail++; $display("FAIL all_degen got resp=%h tie=%h lat=%0d want 0 F 4", response, tie_mask, lat);
    end
    ack();
  endtask

  task automatic test_tie();
    exp_t e; bit ok; int lat;
    set_meas(0, 100, 90); set_meas(1, 30, 200); set_meas(2, 50, 50); set_meas(3, 7, 3);
    send(16'h1B1B);
    wait_resp(ok, lat);
    e = sb.pop_front();
    n_tests++;
    if (!ok || response !== 4'h9 || tie_mask !== 4'h4 || response !== e.resp) begin
      n_fail++; $display("FAIL tie_resp got resp=%h tie=%h want 9 4", response, tie_mask);
    end
    ack();
  endtask

  task automatic test_hold_done();
    exp_t e; bit ok; int lat;
    logic [N_BITS-1:0] r0, t0;
    logic [SEL_W-1:0] sa0, sb0;
    set_meas(0, 10, 20); set_meas(1, 90, 20); set_meas(2, 5, 6); set_meas(3, 60, 59);
    send(16'h1B1B);
    wait_resp(ok, lat);
    e = sb.pop_front();
    n_tests++;
    if (!ok || response !== e.resp || tie_mask !== e.tie) begin
      n_fail++; $display("FAIL hold_resp got resp=%h tie=%h want %h %h", response, tie_mask, e.resp, e.tie);
    end
    r0 = response; t0 = tie_mask; sa0 = sel_a; sb0 = sel_b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_valid = (i == 3);
      challenge   = 16'hA3C6;
      @(posedge clk); #1;
      n_tests++;
      if (response !== r0 || tie_mask !== t0 || resp_valid !== 1'b1 || start_ready !== 1'b0 ||
          sel_a !== sa0 || sel_b !== sb0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL hold_stable cyc%0d got resp=%h tie=%h v=%b rdy=%b sel=%0d/%0d want %h %h 1 0 %0d/%0d",
                           i, response, tie_mask, resp_valid, start_ready, sel_a, sel_b, r0, t0, sa0, sb0);
      end
    end
    start_valid = 1'b0;
    ack();
    n_tests++;
    if (resp_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release got v=%b rdy=%b busy=%b want 0 1 0", resp_valid, start_ready, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || osc_en !== 1'b0) begin
      n_fail++; $display("FAIL no_relatch got busy=%b osc=%b want 0 0", busy, osc_en);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok; int lat;
    bit found;
    for (int k = 0; k < 4; k++) set_meas(k, 100, 90);
    send(16'h1B1B);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (run_cnt == int'(RUNS) + 1 && osc_en === 1'b1 && cnt_clr === 1'b0) begin found = 1; break; end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL midrst_reach bit1 measure not seen"); end
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (osc_en !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 || start_ready !== 1'b1 || cnt_clr !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got osc=%b busy=%b v=%b rdy=%b clr=%b want 0 0 0 1 0",
                         osc_en, busy, resp_valid, start_ready, cnt_clr);
    end
    @(negedge clk); rst = 1'b0;
    void'(sb.pop_front());
    set_meas(0, 3, 4); set_meas(1, 9, 8); set_meas(2, 70, 70); set_meas(3, 1, 0);
    send(16'h1B1B);
    wait_resp(ok, lat);
    e = sb.pop_front();
    n_tests++;
    if (!ok || response !== e.resp || tie_mask !== e.tie || lat !== e.lat) begin
      n_fail++; $display("FAIL midrst_after got resp=%h tie=%h lat=%0d want %h %h %0d",
                         response, tie_mask, lat, e.resp, e.tie, e.lat);
    end
    ack();
  endtask

  task automatic test_random();
    exp_t e; bit ok; int lat;
    logic [CH_W-1:0] ch;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 32; k++) begin
        tgt_a[k] = CNT_W'($urandom_range(0, 3));
        tgt_b[k] = CNT_W'($urandom_range(0, 3));
      end
      ch = CH_W'($urandom);
      send(ch);
      wait_resp(ok, lat);
      e = sb.pop_front();
      n_tests++;
      if (!ok || response !== e.resp || tie_mask !== e.tie || lat !== e.lat) begin
        n_fail++; $display("FAIL random%0d ch=%h got resp=%h tie=%h lat=%0d want %h %h %0d",
                           n, ch, response, tie_mask, lat, e.resp, e.tie, e.lat);
      end
      ack();
    end
  endtask

`ifdef PUF_MAJORITY_EN
  task automatic test_majority();
    bit ok; int lat;
    tgt_a[0] = 100; tgt_b[0] = 90; tgt_a[1] = 50; tgt_b[1] = 60; tgt_a[2] = 100; tgt_b[2] = 90;
    send(16'h555B);
    wait_resp(ok, lat);
    void'(sb.pop_front());
    n_tests++;
    if (!ok || response !== 4'b0001 || tie_mask !== 4'b1110 || lat !== 67) begin
      n_fail++; $display("FAIL maj_win got resp=%b tie=%b lat=%0d want 0001 1110 67", response, tie_mask, lat);
    end
    ack();
    tgt_a[0] = 60; tgt_b[0] = 70; tgt_a[1] = 80; tgt_b[1] = 80; tgt_a[2] = 90; tgt_b[2] = 10;
    send(16'h555B);
    wait_resp(ok, lat);
    void'(sb.pop_front());
    n_tests++;
    if (!ok || response !== 4'b0000 || tie_mask !== 4'b1111) begin
      n_fail++; $display("FAIL maj_lose got resp=%b tie=%b want 0000 1111", response, tie_mask);
    end
    ack();
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL global_timeout bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_all_greater();
    test_degenerate();
    test_tie();
    test_hold_done();
    test_reset_mid();
    test_random();
`ifdef PUF_MAJORITY_EN
    test_majority();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
